// File: rtl/mac_pipe_k_if.sv
// Streaming port bundle for mac_pipe_k: beat input channel and result output channel.
`timescale 1ns/1ps
interface mac_pipe_k_if #(
    parameter int NBITS = 16,
    parameter int NTAPS = 9
);
    // Both channels use valid/ready: a transfer happens on a rising clk edge where
    // valid && ready; the sender holds payload stable while valid && !ready, and
    // ready may be computed without looking at valid.
    logic                     in_valid;
    logic                     in_ready;
    logic [NTAPS*NBITS-1:0]   inputs;
    logic [NTAPS*NBITS-1:0]   weights;
    logic                     relu_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [NBITS-1:0]         P;

    modport master (
        output in_valid, inputs, weights, relu_en, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, inputs, weights, relu_en, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/mac_pipe_k.sv
// Three-stage streaming MAC: parallel truncated multiplies, carry-save reduction,
// then accumulation of NCH beats into one result with optional ReLU.
`timescale 1ns/1ps
module mac_pipe_k #(
    parameter int NBITS = 16,
    parameter int NTAPS = 9,
    parameter int NCH   = 4
) (
    input  logic clk,
    input  logic reset,
    mac_pipe_k_if.slave bus
);
    localparam int              CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(NCH - 1);

    logic                      en;
    logic                      v1, v2, r1, r2;
    logic signed [2*NBITS-1:0] mul_full [NTAPS];
    logic [NBITS-1:0]          prod [NTAPS];
    logic [NBITS-1:0]          ops [NTAPS+2];
    logic [NBITS-1:0]          nxt [NTAPS+2];
    logic [NBITS-1:0]          tree_sum, sum, acc, acc_new, p_q;
    logic [CW-1:0]             cnt;
    logic                      ov_q;

    // A held, unaccepted result stalls every stage at once.
    assign en            = !(ov_q && !bus.out_ready);
    assign bus.in_ready  = en;
    assign bus.out_valid = ov_q;
    assign bus.P         = p_q;

    always_comb begin
        for (int m = 0; m < NTAPS; m++) begin
            mul_full[m] = $signed(bus.inputs[m*NBITS +: NBITS]) *
                          $signed(bus.weights[m*NBITS +: NBITS]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            r1 <= 1'b0;
            for (int m = 0; m < NTAPS; m++) prod[m] <= '0;
        end else if (en) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r1 <= bus.relu_en;
                for (int m = 0; m < NTAPS; m++) prod[m] <= mul_full[m][NBITS-1:0];
            end
        end
    end

    // 3:2 compressor levels until two operands remain; leftovers pass through a level.
    always_comb begin
        int n;
        int k;
        for (int i = 0; i < NTAPS + 2; i++) ops[i] = (i < NTAPS) ? prod[i] : '0;
        for (int i = 0; i < NTAPS + 2; i++) nxt[i] = '0;
        n = NTAPS;
        k = 0;
        for (int lvl = 0; lvl < NTAPS; lvl++) begin
            if (n > 2) begin
                k = 0;
                for (int i = 0; i < NTAPS + 2; i++) nxt[i] = '0;
                for (int j = 0; j < NTAPS; j++) begin
                    if ((j % 3 == 0) && (j + 2 < n)) begin
                        nxt[k]     = ops[j] ^ ops[j+1] ^ ops[j+2];
                        nxt[k + 1] = ((ops[j] & ops[j+1]) | (ops[j] & ops[j+2]) |
                                      (ops[j+1] & ops[j+2])) << 1;
                        k = k + 2;
                    end else if ((j >= (n / 3) * 3) && (j < n)) begin
                        nxt[k] = ops[j];
                        k = k + 1;
                    end
                end
                for (int i = 0; i < NTAPS + 2; i++) ops[i] = nxt[i];
                n = k;
            end
        end
        tree_sum = ops[0] + ops[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2  <= 1'b0;
            r2  <= 1'b0;
            sum <= '0;
        end else if (en) begin
            v2  <= v1;
            r2  <= r1;
            sum <= tree_sum;
        end
    end

    assign acc_new = (cnt == '0) ? sum : acc + sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            cnt  <= '0;
            p_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            if (ov_q && bus.out_ready) ov_q <= 1'b0;
            if (en && v2) begin
                if (cnt == LAST) begin
                    // ReLU flag comes from the group's final beat.
                    p_q  <= (r2 && acc_new[NBITS-1]) ? '0 : acc_new;
                    ov_q <= 1'b1;
                    cnt  <= '0;
                end else begin
                    acc <= acc_new;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe_k.sv
// Directed bench for mac_pipe_k: latency, signed/ReLU, wrap, backpressure, reset, NCH=1 streaming.
`timescale 1ns/1ps
module tb_mac_pipe_k;
  localparam int NB = 16;
  localparam int NT = 9;

  logic clk;
  logic reset;
  int total;
  int bad;
  logic [NB-1:0] exp_q[$];

  mac_pipe_k_if #(.NBITS(NB), .NTAPS(NT)) bus4 ();
  mac_pipe_k_if #(.NBITS(NB), .NTAPS(NT)) bus1 ();

  mac_pipe_k #(.NBITS(NB), .NTAPS(NT), .NCH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  mac_pipe_k #(.NBITS(NB), .NTAPS(NT), .NCH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT*NB-1:0] pack_all(input logic [NB-1:0] v);
    logic [NT*NB-1:0] r;
    for (int m = 0; m < NT; m++) r[m*NB +: NB] = v;
    return r;
  endfunction

  function automatic logic [NT*NB-1:0] pack_ramp();
    logic [NT*NB-1:0] r;
    for (int m = 0; m < NT; m++) r[m*NB +: NB] = NB'(m + 1);
    return r;
  endfunction

  // driver tasks
  task automatic drive4(input logic v, input logic [NB-1:0] a, input logic [NB-1:0] w,
                        input logic relu);
    bus4.in_valid = v;
    bus4.inputs   = pack_all(a);
    bus4.weights  = pack_all(w);
    bus4.relu_en  = relu;
  endtask

  task automatic drive1(input logic v, input logic [NB-1:0] a, input logic [NB-1:0] w);
    bus1.in_valid = v;
    bus1.inputs   = pack_all(a);
    bus1.weights  = pack_all(w);
    bus1.relu_en  = 1'b0;
  endtask

  task automatic run_group4(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] w,
                            input logic relu_last, input logic [NB-1:0] exp);
    for (int b = 0; b < 4; b++) begin
      drive4(1'b1, a, w, (b == 3) ? relu_last : 1'b0);
      tick();
    end
    drive4(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (bus4.out_valid) break;
      tick();
    end
    check({tag, "_valid"}, bus4.out_valid, 1);
    check({tag, "_p"}, bus4.P, exp);
    tick();
    check({tag, "_drop"}, bus4.out_valid, 0);
  endtask

  initial begin
    int k;
    int got;
    int stall_left;
    logic stalled;
    logic acc_prev;
    logic [NB-1:0] held;
    logic [NB-1:0] exp;

    total = 0;
    bad = 0;
    reset = 1'b0;
    drive4(1'b0, '0, '0, 1'b0);
    drive1(1'b0, '0, '0);
    bus4.out_ready = 1'b1;
    bus1.out_ready = 1'b1;

    // reset state
    tick();
    tick();
    check("rst_in_ready", bus4.in_ready, 1);
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_p", bus4.P, 0);
    reset = 1'b1;

    // latency: beats in cycles 0..3, result visible only in cycle 6
    for (int c = 0; c < 4; c++) begin
      drive4(1'b1, 16'd1, 16'd2, 1'b0);
      tick();
    end
    drive4(1'b0, '0, '0, 1'b0);
    check("lat_c4_valid", bus4.out_valid, 0);
    tick();
    check("lat_c5_valid", bus4.out_valid, 0);
    tick();
    check("lat_c6_valid", bus4.out_valid, 1);
    check("lat_c6_p", bus4.P, 16'h0048);
    tick();
    check("lat_c7_valid", bus4.out_valid, 0);

    // signed, ReLU, wrap
    run_group4("neg_norelu", 16'hFFFF, 16'd3, 1'b0, 16'hFF94);
    run_group4("neg_relu", 16'hFFFF, 16'd3, 1'b1, 16'h0000);
    run_group4("pos_relu", 16'd1, 16'd2, 1'b1, 16'h0048);
    run_group4("wrap_zero", 16'h0100, 16'h0100, 1'b0, 16'h0000);
    run_group4("wrap_7fff", 16'h7FFF, 16'd1, 1'b0, 16'hFFDC);

    // backpressure: beat k uses inputs k+1 on every tap, weights 1..9 -> beat sum (k+1)*45
    exp_q.push_back(16'd450);
    exp_q.push_back(16'd1170);
    exp_q.push_back(16'd1890);
    k = 0;
    got = 0;
    stall_left = 0;
    stalled = 1'b0;
    acc_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      if (acc_prev) k++;
      if (!stalled && bus4.out_valid) begin
        stalled = 1'b1;
        stall_left = 5;
        held = bus4.P;
      end
      bus4.out_ready = (stall_left == 0);
      bus4.in_valid  = (k < 12);
      bus4.inputs    = pack_all(NB'(k + 1));
      bus4.weights   = pack_ramp();
      bus4.relu_en   = 1'b0;
      #1;
      if (stall_left > 0) begin
        check("stall_in_ready", bus4.in_ready, 0);
        check("stall_out_valid", bus4.out_valid, 1);
        check("stall_p", bus4.P, held);
        stall_left--;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("bp_result", bus4.P, exp);
        end else begin
          check("bp_extra_result", 1, 0);
        end
        got++;
      end
      acc_prev = bus4.in_valid && bus4.in_ready;
      tick();
    end
    check("bp_stalled", stalled, 1);
    check("bp_count", got, 3);
    check("bp_beats", k, 12);
    check("bp_queue_empty", exp_q.size(), 0);
    drive4(1'b0, '0, '0, 1'b0);
    bus4.out_ready = 1'b1;
    tick();

    // reset mid-group
    drive4(1'b1, 16'd5, 16'd1, 1'b0);
    tick();
    tick();
    drive4(1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", bus4.out_valid, 0);
    check("midrst_p", bus4.P, 0);
    check("midrst_in_ready", bus4.in_ready, 1);
    tick();
    reset = 1'b1;
    run_group4("post_rst", 16'd2, 16'd1, 1'b0, 16'h0048);

    // NCH=1, alternating bubbles: beat j at cycle 2j -> P=9*(j+1) in cycle 2j+3
    for (int c = 0; c < 12; c++) begin
      logic ev;
      ev = (c >= 3) && ((c - 3) % 2 == 0) && ((c - 3) / 2 < 4);
      check("alt_valid", bus1.out_valid, ev);
      if (ev) check("alt_p", bus1.P, 9 * ((c - 3) / 2 + 1));
      drive1((c % 2 == 0) && (c < 8), NB'(c / 2 + 1), 16'd1);
      tick();
    end

    // NCH=1, back-to-back beats with simultaneous handshakes
    for (int c = 0; c < 7; c++) begin
      logic ev;
      ev = (c >= 3) && (c < 6);
      check("b2b_valid", bus1.out_valid, ev);
      if (ev) check("b2b_p", bus1.P, 18 * (c - 2));
      drive1(c < 3, NB'(c + 1), 16'd2);
      tick();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
